// File: rtl/watchdog_supervisor.sv
// Watchdog supervisor: gathers per-task check-ins, restarts the shared
// watchdog, and escalates a timeout to an interrupt, then a reset request.
module watchdog_supervisor #(
  parameter int NUM_TASKS    = 4,
  parameter int GRACE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic [NUM_TASKS-1:0] task_kick,
  input  logic                 irq_ack,
  input  logic                 wd_timeout,
  output logic                 wd_enable,
  output logic                 wd_restart,
  output logic                 irq_pending,
  output logic [NUM_TASKS-1:0] expired_mask,
  output logic                 sys_reset_req
);

  localparam int GW = $clog2(GRACE_CYCLES + 1);
  localparam logic [GW-1:0] GLAST = GW'(GRACE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ARMING, RUN, WARN, FIRE
  } state_t;

  state_t               state, state_d;
  logic [NUM_TASKS-1:0] kick_seen, kick_seen_d;
  logic [NUM_TASKS-1:0] seen_all, mask_d;
  logic [GW-1:0]        grace, grace_d;
  logic                 en_d, restart_d, irq_d, sys_d;
  logic                 all_in, taken;

  assign seen_all = kick_seen | task_kick;
  assign all_in   = &seen_all;
  // a timeout seen while restarting is stale and must not count
  assign taken    = wd_timeout & ~wd_restart;

  always_comb begin
    state_d     = state;
    kick_seen_d = kick_seen;
    mask_d      = expired_mask;
    grace_d     = grace;
    en_d        = wd_enable;
    restart_d   = 1'b0;
    irq_d       = irq_pending;
    sys_d       = sys_reset_req;
    unique case (state)
      IDLE: begin
        en_d  = 1'b0;
        irq_d = 1'b0;
        if (arm) begin
          state_d     = ARMING;
          en_d        = 1'b1;
          restart_d   = 1'b1;
          kick_seen_d = '0;
        end
      end
      ARMING: begin
        state_d     = RUN;
        en_d        = 1'b1;
        kick_seen_d = '0;
      end
      RUN: begin
        en_d  = 1'b1;
        irq_d = 1'b0;
        if (!arm) begin
          state_d     = IDLE;
          en_d        = 1'b0;
          kick_seen_d = '0;
        end else if (taken) begin
          state_d = WARN;
          irq_d   = 1'b1;
          mask_d  = ~seen_all;
          grace_d = '0;
        end else if (all_in && !wd_restart) begin
          restart_d   = 1'b1;
          kick_seen_d = '0;
        end else begin
          kick_seen_d = seen_all;
        end
      end
      WARN: begin
        en_d  = 1'b1;
        irq_d = 1'b1;
        if (irq_ack) begin
          state_d     = RUN;
          restart_d   = 1'b1;
          irq_d       = 1'b0;
          kick_seen_d = '0;
        end else if (!arm) begin
          state_d     = IDLE;
          en_d        = 1'b0;
          irq_d       = 1'b0;
          kick_seen_d = '0;
        end else if (grace == GLAST) begin
          state_d = FIRE;
          en_d    = 1'b0;
          sys_d   = 1'b1;
        end else begin
          grace_d = grace + 1'b1;
        end
      end
      FIRE: begin
        en_d  = 1'b0;
        irq_d = 1'b1;
        sys_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      kick_seen     <= '0;
      grace         <= '0;
      wd_enable     <= 1'b0;
      wd_restart    <= 1'b0;
      irq_pending   <= 1'b0;
      expired_mask  <= '0;
      sys_reset_req <= 1'b0;
    end else begin
      state         <= state_d;
      kick_seen     <= kick_seen_d;
      grace         <= grace_d;
      wd_enable     <= en_d;
      wd_restart    <= restart_d;
      irq_pending   <= irq_d;
      expired_mask  <= mask_d;
      sys_reset_req <= sys_d;
    end
  end

endmodule

// File: tb/tb_watchdog_supervisor.sv
// Directed bench for watchdog_supervisor with a behavioural 4-bit
// watchdog closing the loop on wd_enable/wd_restart/wd_timeout.
module tb_watchdog_supervisor;

  localparam int NT = 4;
  localparam int GC = 8;
  // restart->clear (1) + clear->timeout (15) + timeout->irq (1)
  localparam int IRQ_LAT = 17;

  logic          clk = 1'b0;
  logic          reset, arm, irq_ack;
  logic          wd_timeout, wd_enable, wd_restart;
  logic          irq_pending, sys_reset_req;
  logic [NT-1:0] task_kick, expired_mask;
  logic [3:0]    wd_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_rs = 0;
  int rise;

  always #5 clk = ~clk;

  watchdog_supervisor #(.NUM_TASKS(NT), .GRACE_CYCLES(GC)) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .task_kick    (task_kick),
    .irq_ack      (irq_ack),
    .wd_timeout   (wd_timeout),
    .wd_enable    (wd_enable),
    .wd_restart   (wd_restart),
    .irq_pending  (irq_pending),
    .expired_mask (expired_mask),
    .sys_reset_req(sys_reset_req)
  );

  always @(posedge clk) begin
    if (reset || wd_restart) wd_cnt <= 4'd0;
    else if (wd_enable && wd_cnt != 4'hf) wd_cnt <= wd_cnt + 4'd1;
  end
  assign wd_timeout = (wd_cnt == 4'hf);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    if (wd_restart === 1'b1) last_rs = cyc;
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [NT-1:0] pat(input int c,
                                        input logic [NT-1:0] en);
    logic [NT-1:0] k;
    k = '0;
    case (c % 10)
      2: k = 4'b0001;
      4: k = 4'b0010;
      6: k = 4'b0100;
      8: k = 4'b1000;
      default: k = '0;
    endcase
    return k & en;
  endfunction

  task automatic wait_irq(input logic [NT-1:0] en, output int r);
    r = -1;
    for (int k = 0; k < 60; k++) begin
      if (irq_pending === 1'b1) begin
        r = cyc;
        break;
      end
      task_kick = pat(cyc, en);
      step();
    end
    task_kick = '0;
    chk("irq_rise", 32'(irq_pending), 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, 32'(wd_enable), 0);
    chk({tag, "_rs"}, 32'(wd_restart), 0);
    chk({tag, "_irq"}, 32'(irq_pending), 0);
    chk({tag, "_mask"}, 32'(expired_mask), 0);
    chk({tag, "_sys"}, 32'(sys_reset_req), 0);
  endtask

  initial begin
    reset = 1'b1;
    arm = 1'b0;
    irq_ack = 1'b0;
    task_kick = '0;
    step();
    step();
    chk_zero("reset");
    reset = 1'b0;
    step();

    // arming at cycle 0
    cyc = 0;
    arm = 1'b1;
    step();
    chk("arm_rs1", 32'(wd_restart), 1);
    chk("arm_en1", 32'(wd_enable), 1);
    chk("arm_irq1", 32'(irq_pending), 0);
    step();
    chk("arm_rs2", 32'(wd_restart), 0);
    chk("arm_en2", 32'(wd_enable), 1);

    // healthy rounds
    for (int c = 2; c < 202; c++) begin
      chk("run_rs", 32'(wd_restart), 32'(c % 10 == 9));
      chk("run_irq", 32'(irq_pending), 0);
      chk("run_sys", 32'(sys_reset_req), 0);
      task_kick = pat(c, 4'b1111);
      step();
    end
    task_kick = '0;

    // task 2 missing, acknowledged in 3rd warn cycle
    wait_irq(4'b1011, rise);
    chk("miss_lat", rise - last_rs, IRQ_LAT);
    chk("miss_mask", 32'(expired_mask), 4);
    step();
    step();
    chk("warn_irq", 32'(irq_pending), 1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("ack_rs", 32'(wd_restart), 1);
    chk("ack_irq", 32'(irq_pending), 0);
    chk("ack_mask", 32'(expired_mask), 4);
    step();
    chk("ack_rs2", 32'(wd_restart), 0);
    chk("ack_en", 32'(wd_enable), 1);
    task_kick = 4'b1111;
    step();
    task_kick = '0;
    chk("run_again", 32'(wd_restart), 1);

    // escalation without ack
    wait_irq(4'b0000, rise);
    chk("esc_lat", rise - last_rs, IRQ_LAT);
    chk("esc_mask", 32'(expired_mask), 15);
    for (int k = 0; k <= GC; k++) begin
      chk("esc_sys", 32'(sys_reset_req), 32'(k == GC));
      chk("esc_irq", 32'(irq_pending), 1);
      if (k < GC) step();
    end
    chk("fire_en", 32'(wd_enable), 0);
    arm = 1'b0;
    irq_ack = 1'b1;
    repeat (3) step();
    chk("fire_sys", 32'(sys_reset_req), 1);
    chk("fire_irq", 32'(irq_pending), 1);
    irq_ack = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_zero("fire_rst");

    // disarm mid-run, then re-arm with stale kicks
    step();
    arm = 1'b1;
    step();
    chk("rearm_rs", 32'(wd_restart), 1);
    step();
    chk("rearm_rs2", 32'(wd_restart), 0);
    task_kick = 4'b0011;
    step();
    task_kick = '0;
    arm = 1'b0;
    step();
    chk("dis_en", 32'(wd_enable), 0);
    arm = 1'b1;
    step();
    chk("rearm2_rs", 32'(wd_restart), 1);
    step();
    chk("rearm2_rs2", 32'(wd_restart), 0);
    task_kick = 4'b1100;
    step();
    chk("stale_kick", 32'(wd_restart), 0);
    task_kick = 4'b0011;
    step();
    task_kick = '0;
    chk("fresh_done", 32'(wd_restart), 1);

    // completion colliding with a taken timeout
    repeat (16) step();
    task_kick = 4'b1111;
    step();
    task_kick = '0;
    chk("col_irq", 32'(irq_pending), 1);
    chk("col_mask", 32'(expired_mask), 0);
    chk("col_rs", 32'(wd_restart), 0);
    step();
    chk("col_rs2", 32'(wd_restart), 0);
    chk("col_warn", 32'(irq_pending), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_zero("warn_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
